// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int unsigned MAX_LENGTH = 32;
    localparam logic [MAX_LENGTH-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    // IF/ID pipeline payload: valid bit plus PC, PC+4 and instruction word.
    typedef struct packed {
        logic                  valid;
        logic [MAX_LENGTH-1:0] pc;
        logic [MAX_LENGTH-1:0] pc_plus4;
        logic [MAX_LENGTH-1:0] instr;
    } if_id_t;

    typedef enum logic [1:0] {
        FetchReq    = 2'd0,
        FetchHold   = 2'd1,
        FetchSquash = 2'd2
    } fetch_state_e;

    // Sequential PC step; wraps modulo 2^32.
    function automatic logic [MAX_LENGTH-1:0] pc_inc(input logic [MAX_LENGTH-1:0] pc);
        return pc + 32'd4;
    endfunction

    // Instructions are word aligned, so the two low address bits are dropped.
    function automatic logic [MAX_LENGTH-1:0] align_word(input logic [MAX_LENGTH-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: payload plus valid bit with load/flush/hold controls.
module if_id_register import fetch_stage_pkg::*; #(
    parameter logic [MAX_LENGTH-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t nop_entry;

    assign nop_entry = '{valid: 1'b0, pc: '0, pc_plus4: '0, instr: NOP_INSTR};

    // Reset and flush both return to the bubble; flush beats load; otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            q <= nop_entry;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, skid buffer
// for frozen responses and branch redirect with wrong-path squash.
module fetch_stage import fetch_stage_pkg::*; #(
    parameter logic [MAX_LENGTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [MAX_LENGTH-1:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hazard_detected,
    input  logic                  branch_taken,
    input  logic [MAX_LENGTH-1:0] branch_target,
    output logic                  imem_req,
    output logic [MAX_LENGTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [MAX_LENGTH-1:0] imem_rdata,
    output logic                  id_valid,
    output logic [MAX_LENGTH-1:0] id_pc,
    output logic [MAX_LENGTH-1:0] id_pc_plus4,
    output logic [MAX_LENGTH-1:0] id_instruction
);

    fetch_state_e          state_q, state_d;
    logic [MAX_LENGTH-1:0] pc_q, pc_d;
    logic [MAX_LENGTH-1:0] redirect_q, redirect_d;
    logic [MAX_LENGTH-1:0] skid_instr_q, skid_instr_d;
    logic [MAX_LENGTH-1:0] skid_pc_q, skid_pc_d;
    logic                  skid_valid_q, skid_valid_d;
    logic                  req_en_q;
    logic                  ack_accept;
    logic                  outstanding;
    logic                  ifid_load, ifid_flush;
    if_id_t                ifid_d, ifid_q;

    // req_en_q keeps the request low for the reset cycle so a stale ack is ignored.
    assign imem_req    = ((state_q == FetchReq) && req_en_q) || (state_q == FetchSquash);
    assign imem_addr   = pc_q;
    assign ack_accept  = imem_req && imem_ack;
    assign outstanding = imem_req && !imem_ack;

    // Next-state, PC, skid and IF/ID control; branch redirect overrides everything.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redirect_d   = redirect_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;
        ifid_d       = '{valid: 1'b1, pc: pc_q, pc_plus4: pc_inc(pc_q), instr: imem_rdata};

        if (branch_taken) begin
            ifid_flush   = 1'b1;
            skid_valid_d = 1'b0;
            skid_instr_d = NOP_INSTR;
            skid_pc_d    = '0;
            if (outstanding) begin
                // Keep the old address on the bus until the wrong-path ack drains.
                redirect_d = align_word(branch_target);
                state_d    = FetchSquash;
            end else begin
                pc_d    = align_word(branch_target);
                state_d = FetchReq;
            end
        end else begin
            unique case (state_q)
                FetchReq: begin
                    if (ack_accept) begin
                        pc_d = pc_inc(pc_q);
                        if (hazard_detected) begin
                            skid_instr_d = imem_rdata;
                            skid_pc_d    = pc_q;
                            skid_valid_d = 1'b1;
                            state_d      = FetchHold;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end else if (!hazard_detected) begin
                        // No new word this cycle: insert a bubble.
                        ifid_flush = 1'b1;
                    end
                end
                FetchHold: begin
                    if (!hazard_detected) begin
                        ifid_load    = 1'b1;
                        ifid_d       = '{valid: skid_valid_q, pc: skid_pc_q,
                                         pc_plus4: pc_inc(skid_pc_q), instr: skid_instr_q};
                        skid_valid_d = 1'b0;
                        state_d      = FetchReq;
                    end
                end
                FetchSquash: begin
                    ifid_flush = 1'b1;
                    if (imem_ack) begin
                        pc_d    = redirect_q;
                        state_d = FetchReq;
                    end
                end
                default: begin
                    state_d = FetchReq;
                end
            endcase
        end
    end

    // State, PC, redirect and skid registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= FetchReq;
            pc_q         <= RESET_PC;
            redirect_q   <= RESET_PC;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            req_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redirect_q   <= redirect_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
            req_en_q     <= 1'b1;
        end
    end

    if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_register (
        .clk   (clk),
        .rst   (rst),
        .load  (ifid_load),
        .flush (ifid_flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign id_valid       = ifid_q.valid;
    assign id_pc          = ifid_q.pc;
    assign id_pc_plus4    = ifid_q.pc_plus4;
    assign id_instruction = ifid_q.instr;

endmodule
